// File: rtl/vga_fb_arbiter.sv
// Frame-buffer RAM arbiter: the VGA scan port owns the RAM during active display,
// and two round-robin writers share it during blanking. Optional macro: FB_ARB_DROP_CNT_EN.
//
// state | meaning
// ------+--------------------------------------------------------------
// SCAN  | active display; RAM address comes from the VGA scan port
// IDLE  | blanking, no eligible writer; RAM address/data hold
// WRITE | blanking; one writer granted and its word presented to RAM
module vga_fb_arbiter #(
  parameter int FB_SIZE = 307200,
  parameter int AW      = 19
) (
  input  logic          iVGA_CLK,
  input  logic          iRST_n,
  input  logic          iBLANK_n,
  input  logic [AW-1:0] iVGA_ADDR,
  output logic [23:0]   oVGA_DATA,
  input  logic          iREQ0,
  input  logic          iREQ1,
  input  logic [AW-1:0] iADDR0,
  input  logic [AW-1:0] iADDR1,
  input  logic [23:0]   iDATA0,
  input  logic [23:0]   iDATA1,
  output logic          oGNT0,
  output logic          oGNT1,
  output logic [AW-1:0] oMEM_ADDR,
  output logic [23:0]   oMEM_WDATA,
  output logic          oMEM_WE,
  input  logic [23:0]   iMEM_RDATA,
  output logic [15:0]   oDROP_CNT
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  localparam logic [AW:0] LP_FB_SIZE = (AW+1)'(FB_SIZE);

  state_t        r_state;
  state_t        w_nxt_state;
  logic          r_ptr;
  logic          r_rst_done;
  logic          r_gnt0;
  logic          r_gnt1;
  logic          r_we;
  logic [AW-1:0] r_mem_addr;
  logic [23:0]   r_mem_wdata;
  logic [23:0]   r_vga_data;

  logic          w_elig0;
  logic          w_elig1;
  logic          w_sel;
  logic [AW-1:0] w_wr_addr;
  logic [23:0]   w_wr_data;
  logic          w_in_range;

  // r_rst_done holds off grants for the first edge after reset release;
  // a writer whose grant is showing now is not eligible again this edge.
  assign w_elig0 = iREQ0 & ~r_gnt0 & r_rst_done;
  assign w_elig1 = iREQ1 & ~r_gnt1 & r_rst_done;

  always_comb begin
    w_nxt_state = S_IDLE;
    w_sel       = 1'b0;
    if (iBLANK_n) begin
      w_nxt_state = S_SCAN;
    end else if (w_elig0 | w_elig1) begin
      w_nxt_state = S_WRITE;
      if (w_elig0 & w_elig1) begin
        w_sel = r_ptr;
      end else begin
        w_sel = w_elig1;
      end
    end
  end

  assign w_wr_addr  = w_sel ? iADDR1 : iADDR0;
  assign w_wr_data  = w_sel ? iDATA1 : iDATA0;
  assign w_in_range = ({1'b0, w_wr_addr} < LP_FB_SIZE);

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  // r_state == S_SCAN doubles as the scan-valid pipeline bit.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_ptr       <= 1'b0;
      r_rst_done  <= 1'b0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_we        <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_vga_data  <= '0;
    end else begin
      r_rst_done <= 1'b1;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_we       <= 1'b0;
      r_vga_data <= (r_state == S_SCAN) ? iMEM_RDATA : 24'h0;
      case (w_nxt_state)
        S_SCAN: begin
          r_mem_addr <= iVGA_ADDR;
        end
        S_WRITE: begin
          r_mem_addr  <= w_wr_addr;
          r_mem_wdata <= w_wr_data;
          r_we        <= w_in_range;
          r_gnt0      <= ~w_sel;
          r_gnt1      <= w_sel;
          r_ptr       <= ~w_sel;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef FB_ARB_DROP_CNT_EN
  logic [15:0] r_drop_cnt;
  logic        w_drop;

  assign w_drop = (w_nxt_state == S_WRITE) & ~w_in_range;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign oDROP_CNT = r_drop_cnt;
`else
  assign oDROP_CNT = 16'h0;
`endif

  assign oGNT0      = r_gnt0;
  assign oGNT1      = r_gnt1;
  assign oMEM_WE    = r_we;
  assign oMEM_ADDR  = r_mem_addr;
  assign oMEM_WDATA = r_mem_wdata;
  assign oVGA_DATA  = r_vga_data;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter; RAM model returns the registered address as data.
module tb_vga_fb_arbiter;

  localparam int AW = 19;

  logic          clk_sys = 1'b0;
  logic          rst_n;
  logic          blank_n;
  logic [AW-1:0] vga_addr;
  logic [23:0]   vga_data;
  logic          req0, req1;
  logic [AW-1:0] addr0, addr1;
  logic [23:0]   data0, data1;
  logic          gnt0, gnt1;
  logic [AW-1:0] mem_addr;
  logic [23:0]   mem_wdata;
  logic          mem_we;
  logic [23:0]   mem_rdata;
  logic [15:0]   drop_cnt;

  int n_total = 0;
  int n_bad   = 0;
  logic [15:0] exp_drop;

  always #5 clk_sys = ~clk_sys;

  assign mem_rdata = {5'b0, mem_addr};

  vga_fb_arbiter #(.FB_SIZE(307200), .AW(AW)) u_dut (
    .iVGA_CLK   (clk_sys),
    .iRST_n     (rst_n),
    .iBLANK_n   (blank_n),
    .iVGA_ADDR  (vga_addr),
    .oVGA_DATA  (vga_data),
    .iREQ0      (req0),
    .iREQ1      (req1),
    .iADDR0     (addr0),
    .iADDR1     (addr1),
    .iDATA0     (data0),
    .iDATA1     (data1),
    .oGNT0      (gnt0),
    .oGNT1      (gnt1),
    .oMEM_ADDR  (mem_addr),
    .oMEM_WDATA (mem_wdata),
    .oMEM_WE    (mem_we),
    .iMEM_RDATA (mem_rdata),
    .oDROP_CNT  (drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; blank_n = 1'b0; vga_addr = '0;
    req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
    chk("rst_vga", 32'(vga_data), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);

    // Request pending across reset release: first edge must not grant.
    req0 = 1'b1; addr0 = 19'd5; data0 = 24'hA5;
    rst_n = 1'b1;
    step();
    chk("early_gnt0", 32'(gnt0), 32'd0);
    step();
    chk("first_gnt0", 32'(gnt0), 32'd1);
    chk("first_we", 32'(mem_we), 32'd1);
    chk("first_addr", 32'(mem_addr), 32'd5);
    chk("first_wdata", 32'(mem_wdata), 32'hA5);
    req0 = 1'b0;
    step();
    chk("idle_we", 32'(mem_we), 32'd0);
    chk("idle_gnt", 32'({gnt1, gnt0}), 32'd0);
    chk("idle_hold_addr", 32'(mem_addr), 32'd5);

    // Scan path: 2 edges from iVGA_ADDR to oVGA_DATA.
    blank_n = 1'b1; vga_addr = 19'd100;
    step();
    chk("scan_addr", 32'(mem_addr), 32'd100);
    chk("scan_we", 32'(mem_we), 32'd0);
    chk("scan_vga0", 32'(vga_data), 32'd0);
    vga_addr = 19'd101;
    step();
    chk("scan_vga100", 32'(vga_data), 32'd100);
    chk("scan_we2", 32'(mem_we), 32'd0);
    blank_n = 1'b0;
    step();
    chk("scan_vga101", 32'(vga_data), 32'd101);
    step();
    chk("scan_vga_off", 32'(vga_data), 32'd0);

    // Pointer is 1 after the first grant; a lone req1 grant returns it to 0.
    req1 = 1'b1; addr1 = 19'd7; data1 = 24'h77;
    step();
    chk("solo_gnt1", 32'({gnt1, gnt0}), 32'b10);
    chk("solo_addr", 32'(mem_addr), 32'd7);
    req1 = 1'b0;
    step();

    // Round-robin with both requests held and pointer at 0.
    req0 = 1'b1; addr0 = 19'd10; data0 = 24'h10;
    req1 = 1'b1; addr1 = 19'd20; data1 = 24'h20;
    step();
    chk("rr1_gnt", 32'({gnt1, gnt0}), 32'b01);
    chk("rr1_addr", 32'(mem_addr), 32'd10);
    step();
    chk("rr2_gnt", 32'({gnt1, gnt0}), 32'b10);
    chk("rr2_addr", 32'(mem_addr), 32'd20);
    chk("rr2_wdata", 32'(mem_wdata), 32'h20);
    step();
    chk("rr3_gnt", 32'({gnt1, gnt0}), 32'b01);
    chk("rr3_we", 32'(mem_we), 32'd1);
    req0 = 1'b0; req1 = 1'b0;
    step();
    chk("rr_idle_gnt", 32'({gnt1, gnt0}), 32'd0);
    chk("rr_hold_addr", 32'(mem_addr), 32'd10);

    // Writer blocked during active display, granted right after blank falls.
    blank_n = 1'b1; vga_addr = 19'd3;
    req0 = 1'b1; addr0 = 19'd30; data0 = 24'h30;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("blank_no_gnt0", 32'(gnt0), 32'd0);
    end
    blank_n = 1'b0;
    step();
    chk("unblank_gnt0", 32'(gnt0), 32'd1);
    chk("unblank_we", 32'(mem_we), 32'd1);
    chk("unblank_addr", 32'(mem_addr), 32'd30);
    req0 = 1'b0; blank_n = 1'b1;
    step();
    chk("reblank_we", 32'(mem_we), 32'd0);
    chk("reblank_addr", 32'(mem_addr), 32'd3);
    blank_n = 1'b0;

    // Out-of-range write and last in-range address.
    req1 = 1'b1; addr1 = 19'd307200; data1 = 24'hDEAD;
    step();
    chk("oor_gnt1", 32'(gnt1), 32'd1);
    chk("oor_we", 32'(mem_we), 32'd0);
`ifdef FB_ARB_DROP_CNT_EN
    exp_drop = 16'd1;
`else
    exp_drop = 16'd0;
`endif
    chk("oor_drop", 32'(drop_cnt), 32'(exp_drop));
    req1 = 1'b0;
    req0 = 1'b1; addr0 = 19'd307199; data0 = 24'hBEEF;
    step();
    chk("last_gnt0", 32'(gnt0), 32'd1);
    chk("last_we", 32'(mem_we), 32'd1);
    chk("last_drop", 32'(drop_cnt), 32'(exp_drop));
    req0 = 1'b0;
    step();

    // Reset mid-write, both requests kept high for retry.
    req0 = 1'b1; addr0 = 19'd40; data0 = 24'h40;
    req1 = 1'b1; addr1 = 19'd50; data1 = 24'h50;
    step();
    chk("pre_rst_we", 32'(mem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_we", 32'(mem_we), 32'd0);
    chk("async_gnt", 32'({gnt1, gnt0}), 32'd0);
    chk("async_addr", 32'(mem_addr), 32'd0);
    chk("async_drop", 32'(drop_cnt), 32'd0);
    @(posedge clk_sys);
    #1 rst_n = 1'b1;
    step();
    chk("retry_early", 32'({gnt1, gnt0}), 32'd0);
    step();
    chk("retry_gnt0", 32'({gnt1, gnt0}), 32'b01);
    chk("retry_addr", 32'(mem_addr), 32'd40);
    req0 = 1'b0;
    step();
    chk("retry_gnt1", 32'({gnt1, gnt0}), 32'b10);
    req1 = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 The block SHALL have parameter FB_SIZE, default 307200, meaning the number of valid frame-buffer words (640x480); write addresses >= FB_SIZE are out of range.
REQ-002 The block SHALL have parameter AW, default 19, meaning the address width in bits.
REQ-003 iVGA_CLK  in  1  single clock; every flop updates on its rising edge.
REQ-004 iRST_n  in  1  asynchronous, active-low reset.
REQ-005 iBLANK_n  in  1  1 = active display; the scan port owns the RAM.
REQ-006 iVGA_ADDR  in  AW  scan read address from the VGA controller.
REQ-007 oVGA_DATA  out  24  scan read pixel, RGB 8:8:8.
REQ-008 iREQ0, iREQ1  in  1 each  write requests.
REQ-009 iADDR0, iADDR1  in  AW each  write addresses.
REQ-010 iDATA0, iDATA1  in  24 each  write data.
REQ-011 oGNT0, oGNT1  out  1 each  one-cycle grant pulses.
REQ-012 oMEM_ADDR  out  AW  RAM address.
REQ-013 oMEM_WDATA  out  24  RAM write data.
REQ-014 oMEM_WE  out  1  RAM write enable.
REQ-015 iMEM_RDATA  in  24  RAM read data, valid one cycle after oMEM_ADDR (synchronous RAM).
REQ-016 oDROP_CNT  out  16  count of out-of-range writes.

Function
REQ-017 All oMEM_*, oGNT* and oVGA_DATA outputs SHALL be registered.
REQ-018 States SHALL be SCAN, IDLE and WRITE, re-evaluated at every edge: iBLANK_n=1 -> SCAN; otherwise any eligible request -> WRITE; otherwise IDLE.
REQ-019 SCAN: oMEM_ADDR SHALL be loaded from iVGA_ADDR with oMEM_WE=0, and the scan-valid pipeline bit SHALL be set.
REQ-020 oVGA_DATA SHALL equal iMEM_RDATA registered one cycle after the SCAN cycle, giving 2 cycles total latency from iVGA_ADDR; it SHALL be 24'h0 when the cycle was not SCAN.
REQ-021 Writers SHALL never be granted while iBLANK_n=1 is sampled; a pending request SHALL wait with no timeout.
REQ-022 WRITE: exactly one requester SHALL be granted per cycle; oMEM_ADDR/oMEM_WDATA SHALL be loaded from that requester; oGNTn SHALL be 1 in the same cycle as oMEM_WE.
REQ-023 Handshake: a requester SHALL hold REQ/ADDR/DATA stable until it samples GNT=1, then drop REQ or present the next word.
REQ-024 A requester whose GNT is currently 1 SHALL be ineligible at that edge, so a REQ still high is not double-granted; the maximum rate per requester is therefore one write every 2 cycles.
REQ-025 Arbitration SHALL be round-robin: a 1-bit pointer selects the preferred requester on contention and toggles to the other requester after each grant; the pointer resets to 0.
REQ-026 If only one requester is eligible, it SHALL be granted regardless of the pointer.
REQ-027 Out-of-range write (address >= FB_SIZE): the grant SHALL still pulse, oMEM_WE SHALL stay 0, and the drop count is handled per REQ-033.
REQ-028 IDLE: oMEM_WE=0 and oGNT*=0; oMEM_ADDR and oMEM_WDATA SHALL hold their values.
REQ-029 On a blank-to-active transition, a write granted in the prior edge SHALL complete; the next cycle SHALL be SCAN.

Reset
REQ-030 While iRST_n=0: state=IDLE, pointer=0, oMEM_ADDR=0, oMEM_WDATA=0, oMEM_WE=0, oGNT0=oGNT1=0, oVGA_DATA=0, scan-valid=0, oDROP_CNT=0.
REQ-031 Reset asserted mid-write SHALL clear oMEM_WE immediately, asynchronously; the interrupted requester SHALL have seen no GNT and SHALL retry.
REQ-032 The first grant SHALL occur no earlier than the second rising edge after iRST_n deasserts.

Configuration
REQ-033 Macro FB_ARB_DROP_CNT_EN: when defined, oDROP_CNT SHALL increment on each out-of-range grant and saturate at 16'hFFFF; when undefined, it SHALL be tied to 0 with no counter logic.

Verification
REQ-034 iBLANK_n=1, iVGA_ADDR=100, iMEM_RDATA model = addr -> oVGA_DATA=100 two edges later, with oMEM_WE=0 throughout.
REQ-035 iBLANK_n=0, both REQ held high, pointer=0 -> grants alternate GNT0, GNT1, GNT0, with each requester granted at most every other cycle.
REQ-036 iBLANK_n=1, iREQ0=1 held for 10 cycles -> no GNT0; iBLANK_n falls -> GNT0 with oMEM_WE=1 within 1 edge.
REQ-037 iADDR1=307200, iREQ1=1, blank -> GNT1=1, oMEM_WE=0, oDROP_CNT 0->1 when the macro is defined and stays 0 when it is not.
REQ-038 iRST_n pulled low during a WRITE cycle -> all outputs 0 asynchronously; after release, the retried request is granted with pointer=0.
